ascon_const_add: RTL and testbench
==================================

Name: ascon_const_add

Overview:
- Constant-addition layer (pC) of the Ascon-128 permutation.
- XORs the round constant selected by round_i into the least-significant byte of state word x2; words x0, x1, x3 and x4 pass through unchanged.
- Sits at the head of the round datapath, ahead of the substitution (pS) and linear (pL) layers.
- This version registers its output: one-cycle latency, with a valid strobe and a round-range error flag.

Parameters:
- NB_ROUNDS, 12, number of entries in the round-constant table; legal round_i values are 0..NB_ROUNDS-1.

Ports:
- clock_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  input state and round are valid this cycle.
- round_i  input  4  round index; selects the constant.
- pc_in_i  input  type_state (5x64)  input state; x0 = pc_in_i[0] ... x4 = pc_in_i[4].
- pc_out_o  output  type_state (5x64)  state after constant addition.
- valid_o  output  1  pc_out_o holds a freshly computed result.
- round_err_o  output  1  the round_i captured for the current result was out of range.

Behaviour:
- Constant definition: c(r) = ((15 - r) << 4) | r, 8 bits, for r = 0..11.
  - Full table: f0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b.
- Datapath:
  - x2_out = x2_in XOR {56'h0, c(round_i)}.
  - All other words are copied bit-exactly.
  - Bit 63 is the MSB of each word.
- Out-of-range round (round_i 12..15):
  - The constant is forced to 8'h00, so the state passes through unchanged.
  - round_err_o = 1 for that result.
- Registering: on each rising clock_i edge where valid_i = 1:
  - pc_out_o is loaded with the computed state.
  - round_err_o is loaded with (round_i >= NB_ROUNDS).
  - valid_o is set to 1.
- Idle cycles: on a rising edge where valid_i = 0, pc_out_o and round_err_o hold their values and valid_o is 0.
- Latency and throughput:
  - Exactly 1 cycle from valid_i to valid_o.
  - Full throughput: back-to-back valid_i is accepted every cycle.
  - No backpressure.
- Reset:
  - While reset_i = 1, asynchronously: pc_out_o = all five words 64'h0, valid_o = 0, round_err_o = 0.
  - Reset asserted mid-stream discards the in-flight result.
  - The first capture occurs on the first rising edge after deassertion where valid_i = 1.
- Combinational restriction: no combinational path from inputs to outputs.
- Error handling: the block performs no checking beyond round_err_o.

Decomposition:
- Shared package ascon_pack holds:
  - type_state: unpacked array [0:4] of logic [63:0].
  - The round-constant table as a 12-entry array of logic [7:0].
  - NB_ROUNDS as a package constant.
- One combinational sub-module is natural: ascon_round_const.
  - Maps round_i (4 bits) to the 8-bit constant, returning 0 for out-of-range indices.
  - ascon_const_add instantiates it and adds the XOR and output registers.

Test Plan:
- Round 0:
  - Stimulus: valid_i = 1, round_i = 0, pc_in_i = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaaff, 4ed0ec0b98c529b7, c8cddf37bcd0284a}.
  - Required next cycle: valid_o = 1, pc_out_o[2] = be263d4d7aecaa0f, other four words unchanged, round_err_o = 0.
- Rounds 6 and 11, same input state:
  - round_i = 6 -> pc_out_o[2] = be263d4d7aecaa69.
  - round_i = 11 -> pc_out_o[2] = be263d4d7aecaab4.
- Full sweep:
  - Stimulus: round_i 0..11 back-to-back with pc_in_i all zeros.
  - Required: pc_out_o[2] low bytes appear one cycle later in order f0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b; all other bits 0; valid_o continuously 1.
- Out-of-range round:
  - Stimulus: round_i = 12, then 15, with the Round 0 input state.
  - Required: pc_out_o equals pc_in_i exactly and round_err_o = 1.
- Reset:
  - Stimulus: assert reset_i asynchronously mid-stream (between clock edges).
  - Required: pc_out_o = 0, valid_o = 0, round_err_o = 0 immediately.
  - After release with valid_i = 0: outputs hold zero and valid_o stays 0 until the next valid_i.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon-128 permutation datapath.
package ascon_pack;

  // Number of rounds in the permutation; legal round indices are 0..NB_ROUNDS-1.
  localparam int NB_ROUNDS = 12;

  // Highest legal round index at the width of the round_i port.
  localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS - 1);

  // Permutation state: five 64-bit words, x0 at index 0, bit 63 is the word MSB.
  typedef logic [63:0] type_state [0:4];

  // Round constants c(r) = ((15 - r) << 4) | r.
  localparam logic [7:0] ROUND_CONST [0:NB_ROUNDS-1] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

endpackage

// File: rtl/ascon_round_const.sv
// Round-constant lookup: maps a round index to its 8-bit constant.
// Indices past the last round map to zero so the state passes through untouched.
module ascon_round_const
  import ascon_pack::*;
(
  input  logic [3:0] round_i,
  output logic [7:0] const_o
);

  // Table lookup with out-of-range indices forced to zero.
  always_comb begin
    // NOTE: defaulting the output first keeps every path assigned, so no latch is inferred.
    const_o = 8'h00;
    if (round_i <= LAST_ROUND) begin
      const_o = ROUND_CONST[round_i];
    end
  end

endmodule

// File: rtl/ascon_const_add.sv
// Ascon pC layer: XORs the round constant into the low byte of x2 and
// registers the result with a valid strobe and a round-range error flag.
// One-cycle latency, full throughput, no path from inputs to outputs.
module ascon_const_add
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       valid_i,
  input  logic [3:0] round_i,
  input  type_state  pc_in_i,
  output type_state  pc_out_o,
  output logic       valid_o,
  output logic       round_err_o
);

  logic [7:0] round_const;
  type_state  next_state;

  ascon_round_const u_round_const (
    .round_i (round_i),
    .const_o (round_const)
  );

  // Constant addition: only the least-significant byte of x2 can change.
  always_comb begin
    next_state    = pc_in_i;
    next_state[2] = pc_in_i[2] ^ {56'h0, round_const};
  end

  // Output register: captures on valid_i, holds data on idle cycles, valid_o strobes.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: this is a 320-bit pipeline register, not a memory array, so clearing it in reset is cheap and gives a defined output.
      pc_out_o    <= '{default: 64'h0};
      valid_o     <= 1'b0;
      round_err_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_o <= valid_i;
      if (valid_i) begin
        pc_out_o    <= next_state;
        round_err_o <= (round_i > LAST_ROUND);
      end
    end
  end

endmodule

// File: tb/tb_ascon_const_add.sv
// Scoreboard bench for ascon_const_add: the driver pushes one expected output
// per clock edge, and a negedge monitor pops and compares it against the DUT.
module tb_ascon_const_add;
  import ascon_pack::*;

  typedef struct {
    logic      valid;
    type_state st;
    logic      err;
  } exp_t;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       valid_i = 1'b0;
  logic [3:0] round_i = 4'd0;
  type_state  pc_in_i = '{default: 64'h0};
  type_state  pc_out_o;
  logic       valid_o;
  logic       round_err_o;

  int checks = 0;
  int errors = 0;

  exp_t      exp_q[$];
  type_state model_state = '{default: 64'h0};
  logic      model_err   = 1'b0;

  ascon_const_add dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .round_i     (round_i),
    .pc_in_i     (pc_in_i),
    .pc_out_o    (pc_out_o),
    .valid_o     (valid_o),
    .round_err_o (round_err_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %h want %h", name, actual, expected);
    end
  endtask

  // Reference constant straight from its arithmetic definition.
  function automatic logic [7:0] c_of(input int r);
    return 8'(((15 - r) << 4) | r);
  endfunction

  // Apply one cycle of stimulus, then record what the output must be after that edge.
  task automatic drive(input logic v, input logic [3:0] r, input type_state st);
    exp_t e;
    valid_i = v;
    round_i = r;
    pc_in_i = st;
    @(posedge clock_i);
    if (v) begin
      model_state = st;
      if (int'(r) < NB_ROUNDS) model_state[2][7:0] = st[2][7:0] ^ c_of(int'(r));
      model_err = (int'(r) >= NB_ROUNDS);
    end
    e.valid = v;
    e.st    = model_state;
    e.err   = model_err;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int w = 0; w < 5; w++) check($sformatf("%s_word%0d", tag, w), pc_out_o[w], 64'h0);
    check({tag, "_valid"}, {63'h0, valid_o}, 64'h0);
    check({tag, "_err"}, {63'h0, round_err_o}, 64'h0);
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  always @(negedge clock_i) begin
    if (!reset_i && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("valid_o", {63'h0, valid_o}, {63'h0, e.valid});
      check("round_err_o", {63'h0, round_err_o}, {63'h0, e.err});
      for (int w = 0; w < 5; w++) check($sformatf("pc_out_o[%0d]", w), pc_out_o[w], e.st[w]);
    end
  end

  type_state ref_in;
  type_state zero_st;
  type_state rnd_st;

  initial begin
    ref_in[0] = 64'h80400c0600000000;
    ref_in[1] = 64'h8a55114d1cb6a9a2;
    ref_in[2] = 64'hbe263d4d7aecaaff;
    ref_in[3] = 64'h4ed0ec0b98c529b7;
    ref_in[4] = 64'hc8cddf37bcd0284a;
    zero_st   = '{default: 64'h0};

    // Reset state while held in reset.
    #3;
    check_zero("reset_init");
    #9;
    reset_i = 1'b0;

    // Directed rounds 0, 6, 11 with the reference state.
    drive(1'b1, 4'd0, ref_in);
    drive(1'b1, 4'd6, ref_in);
    drive(1'b1, 4'd11, ref_in);
    drive(1'b0, 4'd3, zero_st);

    // Spot check of the round-11 literal value, sampled away from the edge.
    // The idle cycle above holds the last captured result.
    #3;
    check("round11_literal", pc_out_o[2], 64'hbe263d4d7aecaab4);
    @(posedge clock_i);
    #1;
    drive(1'b0, 4'd0, zero_st);

    // Full sweep of legal rounds, back to back, on a zero state.
    for (int r = 0; r < NB_ROUNDS; r++) drive(1'b1, 4'(r), zero_st);

    // Out-of-range rounds pass the state through and raise the error flag.
    drive(1'b1, 4'd12, ref_in);
    drive(1'b1, 4'd15, ref_in);
    drive(1'b1, 4'd4, ref_in);

    // Asynchronous reset mid-stream discards the in-flight result.
    drive(1'b1, 4'd2, ref_in);
    valid_i = 1'b0;
    #1;
    reset_i = 1'b1;
    #1;
    check_zero("reset_async");
    exp_q.delete();
    model_state = '{default: 64'h0};
    model_err   = 1'b0;
    repeat (2) @(posedge clock_i);
    #3;
    reset_i = 1'b0;

    // After release with valid_i low the outputs stay zero.
    repeat (3) drive(1'b0, 4'd1, ref_in);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      for (int w = 0; w < 5; w++) rnd_st[w] = {$urandom, $urandom};
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rnd_st);
    end
    drive(1'b0, 4'd0, zero_st);
    drive(1'b0, 4'd0, zero_st);

    // Every expectation must have been consumed by the monitor.
    @(posedge clock_i);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
